// File: rtl/ceres_param.sv
// Shared constants for the machine counter/timer CSR block: CSR addresses,
// hardware event ids and small helpers used by the counter file.
package ceres_param;

    localparam int XLEN            = 32;
    localparam int DEFAULT_NUM_HPM = 4;

    localparam logic [11:0] MCYCLE             = 12'hB00;
    localparam logic [11:0] MINSTRET           = 12'hB02;
    localparam logic [11:0] MHPMCOUNTER3_BASE  = 12'hB03;
    localparam logic [11:0] MCYCLEH            = 12'hB80;
    localparam logic [11:0] MHPMCOUNTER3H_BASE = 12'hB83;
    localparam logic [11:0] CYCLE              = 12'hC00;
    localparam logic [11:0] CYCLEH             = 12'hC80;
    localparam logic [11:0] MCOUNTINHIBIT      = 12'h320;
    localparam logic [11:0] MHPMEVENT3_BASE    = 12'h323;

    typedef enum logic [7:0] {
        EV_NONE       = 8'd0,
        EV_IMISS      = 8'd1,
        EV_DMISS      = 8'd2,
        EV_BR_MISPRED = 8'd3,
        EV_ALU_STALL  = 8'd4,
        EV_FENCEI     = 8'd5,
        EV_LOAD       = 8'd6,
        EV_STORE      = 8'd7,
        EV_BRANCH     = 8'd8
    } hpm_event_e;

    // Counter slot -> CSR number: slot 0 mcycle, slot 1 minstret, slot 2+k hpm(3+k).
    function automatic logic [4:0] cnt_csr_num(input int slot);
        if (slot == 0) return 5'd0;
        if (slot == 1) return 5'd2;
        return 5'(slot + 1);
    endfunction

    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int n = 3; n < 32; n++) begin
            if (n < 3 + num_hpm) m[n] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cs_hpm_counter.sv
// One CNT_WIDTH event counter with split 32-bit low/high writes and an
// optional sticky overflow flag (enabled by CERES_HPM_OVF_EN).
module cs_hpm_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    input  logic                 of_wr_i,
    input  logic                 of_wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 of_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wrap;

    // Any write to this counter takes priority over the increment.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[CNT_WIDTH-1:32] = wdata_i[CNT_WIDTH-33:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign wrap  = inc_i & ~wr_lo_i & ~wr_hi_i & (&cnt_q);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

`ifdef CERES_HPM_OVF_EN
    logic of_q, of_d;

    // Software can only clear the flag; its write beats a same-cycle wrap.
    always_comb begin
        of_d = of_q;
        if (of_wr_i)   of_d = of_q & of_wdata_i;
        else if (wrap) of_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) of_q <= 1'b0;
        else         of_q <= of_d;
    end

    assign of_o = of_q;
`else
    logic unused_of;
    assign unused_of = ^{of_wr_i, of_wdata_i, wrap};
    assign of_o      = 1'b0;
`endif

endmodule

// File: rtl/cs_hpm_counter_file.sv
// Machine counter/timer CSR file: mcycle, minstret, NUM_HPM hpm counters,
// mhpmevent selectors, mcountinhibit and user read shadows. Optional
// overflow flags/interrupt are enabled by CERES_HPM_OVF_EN.
module cs_hpm_counter_file
    import ceres_param::*;
#(
    parameter int NUM_HPM    = DEFAULT_NUM_HPM,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cycle_en_i,
    input  logic                  retire_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [11:0]           csr_idx_i,
    input  logic [XLEN-1:0]       csr_wdata_i,
    output logic [XLEN-1:0]       csr_rdata_o,
    output logic                  csr_hit_o,
    output logic                  ovf_irq_o
);

    localparam int          NUM_CNT  = NUM_HPM + 2;
    localparam int          NUM_SEL  = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic [6:0] grp;
    logic [4:0] num;
    logic       lo_grp, hi_grp, cnt_grp, ev_grp;

    // Every block address is base + CSR number, so decode group and number.
    assign grp     = csr_idx_i[11:5];
    assign num     = csr_idx_i[4:0];
    assign lo_grp  = (grp == MCYCLE[11:5])  | (grp == CYCLE[11:5]);
    assign hi_grp  = (grp == MCYCLEH[11:5]) | (grp == CYCLEH[11:5]);
    assign cnt_grp = lo_grp | hi_grp;
    assign ev_grp  = (grp == MCOUNTINHIBIT[11:5]);

    assign csr_hit_o = (cnt_grp & (num != 5'd1)) | (ev_grp & ((num == 5'd0) | (num >= 5'd3)));

    logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   inc, wr_lo, wr_hi, of_wr, of_flag;
    logic [NUM_SEL-1:0]   ev_hit;
    logic [7:0]           sel_q [NUM_SEL];
    logic [7:0]           sel_d [NUM_SEL];
    logic [31:0]          inh_q, inh_d;

    always_comb begin
        inh_d = inh_q;
        sel_d = sel_q;
        if (wr_en_i && ev_grp) begin
            if (num == 5'd0) inh_d = csr_wdata_i & INH_MASK;
            for (int k = 0; k < NUM_HPM; k++) begin
                if (num == 5'(k + 3)) sel_d[k] = csr_wdata_i[7:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inh_q <= '0;
            for (int k = 0; k < NUM_SEL; k++) sel_q[k] <= '0;
        end else begin
            inh_q <= inh_d;
            for (int k = 0; k < NUM_SEL; k++) sel_q[k] <= sel_d[k];
        end
    end

    // Selector values 0 and above NUM_EVENTS never match an event line.
    always_comb begin
        ev_hit = '0;
        for (int k = 0; k < NUM_HPM; k++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (sel_q[k] == 8'(e + 1) && event_i[e]) ev_hit[k] = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            localparam logic [4:0] N = cnt_csr_num(gi);

            if (gi == 0) begin : g_cycle
                assign inc[gi]   = cycle_en_i & ~inh_q[N];
                assign of_wr[gi] = 1'b0;
            end else if (gi == 1) begin : g_instret
                assign inc[gi]   = retire_i & cycle_en_i & ~inh_q[N];
                assign of_wr[gi] = 1'b0;
            end else begin : g_hpm
                assign inc[gi]   = ev_hit[gi-2] & cycle_en_i & ~inh_q[N];
                assign of_wr[gi] = wr_en_i & ev_grp & (num == N);
            end

            assign wr_lo[gi] = wr_en_i & (grp == MCYCLE[11:5])  & (num == N);
            assign wr_hi[gi] = wr_en_i & (grp == MCYCLEH[11:5]) & (num == N);

            cs_hpm_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_counter (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .inc_i      (inc[gi]),
                .wr_lo_i    (wr_lo[gi]),
                .wr_hi_i    (wr_hi[gi]),
                .wdata_i    (csr_wdata_i),
                .of_wr_i    (of_wr[gi]),
                .of_wdata_i (csr_wdata_i[31]),
                .cnt_o      (cnt[gi]),
                .of_o       (of_flag[gi])
            );
        end
    endgenerate

    logic [63:0] ext;

    always_comb begin
        ext         = '0;
        csr_rdata_o = '0;
        if (rd_en_i) begin
            if (cnt_grp) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (num == cnt_csr_num(i)) ext = 64'(cnt[i]);
                end
                csr_rdata_o = hi_grp ? ext[63:32] : ext[31:0];
            end else if (ev_grp) begin
                if (num == 5'd0) csr_rdata_o = inh_q;
                for (int k = 0; k < NUM_HPM; k++) begin
                    if (num == 5'(k + 3)) csr_rdata_o = {of_flag[k+2], 23'b0, sel_q[k]};
                end
            end
        end
    end

    logic unused_base_of;
    assign unused_base_of = ^of_flag[1:0];

`ifdef CERES_HPM_OVF_EN
    logic ovf_any, irq_q;

    always_comb begin
        ovf_any = 1'b0;
        for (int k = 0; k < NUM_HPM; k++) ovf_any = ovf_any | of_flag[k+2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= ovf_any;
    end

    assign ovf_irq_o = irq_q;
`else
    assign ovf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_cs_hpm_counter_file.sv
// Self-checking bench for cs_hpm_counter_file (NUM_HPM=4, CNT_WIDTH=40) with a
// per-CSR behavioural model and directed literal checks.
module tb_cs_hpm_counter_file;
    import ceres_param::*;

    localparam int          NH    = 4;
    localparam int          CW    = 40;
    localparam int          NE    = 16;
    localparam logic [63:0] CMASK = (64'h1 << CW) - 64'h1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cycle_en_i = 1'b0;
    logic          retire_i = 1'b0;
    logic [NE-1:0] event_i = '0;
    logic          rd_en_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [11:0]   csr_idx_i = '0;
    logic [31:0]   csr_wdata_i = '0;
    logic [31:0]   csr_rdata_o;
    logic          csr_hit_o;
    logic          ovf_irq_o;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    always #5 clk_i = ~clk_i;

    cs_hpm_counter_file #(
        .NUM_HPM    (NH),
        .CNT_WIDTH  (CW),
        .NUM_EVENTS (NE)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cycle_en_i  (cycle_en_i),
        .retire_i    (retire_i),
        .event_i     (event_i),
        .rd_en_i     (rd_en_i),
        .wr_en_i     (wr_en_i),
        .csr_idx_i   (csr_idx_i),
        .csr_wdata_i (csr_wdata_i),
        .csr_rdata_o (csr_rdata_o),
        .csr_hit_o   (csr_hit_o),
        .ovf_irq_o   (ovf_irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s addr=%03h got=%08h expected=%08h @%0t", name, csr_idx_i, act, exp, $time);
        end else begin
            $display("ok   %s addr=%03h value=%08h", name, csr_idx_i, act);
        end
    endtask

    // Model state indexed by CSR number (0 mcycle, 2 minstret, 3.. hpm).
    logic [63:0] m_cnt [32];
    logic [7:0]  m_sel [32];
    logic        m_of  [32];
    logic [31:0] m_inh;
    logic        m_irq;
    logic        irq_next, inc, lo_wr, hi_wr, ev_wr;

    function automatic bit m_impl(input int n);
        return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NH);
    endfunction

    function automatic logic m_hit(input logic [11:0] a);
        logic [11:0] bases [4];
        bases = '{12'hB00, 12'hB80, 12'hC00, 12'hC80};
        for (int b = 0; b < 4; b++) begin
            if (a >= bases[b] && a <= bases[b] + 12'd31 && a != bases[b] + 12'd1) return 1'b1;
        end
        if (a == 12'h320) return 1'b1;
        if (a >= 12'h323 && a <= 12'h33F) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, input logic rd);
        logic [11:0] bases [4];
        logic [63:0] v;
        int n;
        bases = '{12'hB00, 12'hB80, 12'hC00, 12'hC80};
        if (!rd) return 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (a >= bases[b] && a <= bases[b] + 12'd31) begin
                n = int'(a - bases[b]);
                if (!m_impl(n)) return 32'h0;
                v = m_cnt[n];
                return (b == 1 || b == 3) ? v[63:32] : v[31:0];
            end
        end
        if (a == 12'h320) return m_inh;
        if (a >= 12'h323 && a <= 12'h33F) begin
            n = int'(a - 12'h320);
            if (!m_impl(n)) return 32'h0;
            return {m_of[n], 23'b0, m_sel[n]};
        end
        return 32'h0;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < 32; n++) begin
                m_cnt[n] = '0;
                m_sel[n] = '0;
                m_of[n]  = 1'b0;
            end
            m_inh = '0;
            m_irq = 1'b0;
        end else begin
            irq_next = 1'b0;
            for (int n = 3; n < 32; n++) irq_next = irq_next | m_of[n];
            for (int n = 0; n < 32; n++) begin
                if (m_impl(n)) begin
                    inc = cycle_en_i && !m_inh[n] &&
                          ((n == 0) || (n == 2 && retire_i) ||
                           (n >= 3 && m_sel[n] >= 8'd1 && m_sel[n] <= 8'(NE) && event_i[m_sel[n] - 8'd1]));
                    lo_wr = wr_en_i && (csr_idx_i == 12'hB00 + 12'(n));
                    hi_wr = wr_en_i && (csr_idx_i == 12'hB80 + 12'(n));
                    ev_wr = wr_en_i && (n >= 3) && (csr_idx_i == 12'h320 + 12'(n));
                    if (lo_wr) begin
                        m_cnt[n] = {m_cnt[n][63:32], csr_wdata_i};
                    end else if (hi_wr) begin
                        m_cnt[n] = {csr_wdata_i, m_cnt[n][31:0]} & CMASK;
                    end else if (inc) begin
                        if (m_cnt[n] == CMASK) begin
                            m_cnt[n] = '0;
`ifdef CERES_HPM_OVF_EN
                            if (n >= 3 && !ev_wr) m_of[n] = 1'b1;
`endif
                        end else begin
                            m_cnt[n] = m_cnt[n] + 64'd1;
                        end
                    end
                    if (ev_wr) begin
                        m_sel[n] = csr_wdata_i[7:0];
`ifdef CERES_HPM_OVF_EN
                        m_of[n] = m_of[n] & csr_wdata_i[31];
`endif
                    end
                end
            end
            if (wr_en_i && csr_idx_i == 12'h320) m_inh = csr_wdata_i & 32'h0000_007D;
`ifdef CERES_HPM_OVF_EN
            m_irq = irq_next;
`else
            m_irq = 1'b0;
`endif
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cyc_hit", 32'(csr_hit_o), 32'(m_hit(csr_idx_i)));
            check("cyc_rdata", csr_rdata_o, m_read(csr_idx_i, rd_en_i));
            check("cyc_irq", 32'(ovf_irq_o), 32'(m_irq));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        wr_en_i     = 1'b1;
        csr_idx_i   = a;
        csr_wdata_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic expect_read(input string name, input logic [11:0] a, input logic [31:0] exp);
        rd_en_i   = 1'b1;
        csr_idx_i = a;
        #1;
        check(name, csr_rdata_o, exp);
    endtask

    initial begin
        repeat (2) tick();
        rst_ni = 1'b1;
        chk_en = 1'b1;
        expect_read("rst_mcycle", MCYCLE, 32'd0);
        expect_read("rst_inhibit", MCOUNTINHIBIT, 32'd0);
        check("rst_irq", 32'(ovf_irq_o), 32'd0);

        cycle_en_i = 1'b1;
        repeat (10) tick();
        cycle_en_i = 1'b0;
        expect_read("mcycle_10", MCYCLE, 32'd10);
        expect_read("minstret_0", MINSTRET, 32'd0);
        expect_read("hpm3_0", MHPMCOUNTER3_BASE, 32'd0);
        tick();
        cycle_en_i = 1'b1;
        retire_i   = 1'b1;
        repeat (3) tick();
        cycle_en_i = 1'b0;
        repeat (2) tick();
        retire_i = 1'b0;
        expect_read("minstret_3", MINSTRET, 32'd3);
        expect_read("mcycle_13", MCYCLE, 32'd13);

        csr_write(MHPMEVENT3_BASE, 32'(EV_DMISS));
        for (int i = 0; i < 5; i++) begin
            cycle_en_i = 1'b1;
            event_i    = 16'h0002;
            tick();
            event_i = '0;
            tick();
        end
        cycle_en_i = 1'b0;
        event_i    = 16'h0002;
        repeat (2) tick();
        event_i = '0;
        expect_read("hpm3_5", MHPMCOUNTER3_BASE, 32'd5);
        expect_read("hpm3_shadow", 12'hC03, 32'd5);

        cycle_en_i = 1'b1;
        event_i    = 16'h0004;
        csr_write(12'h324, 32'd3);
        event_i    = '0;
        cycle_en_i = 1'b0;
        expect_read("hpm4_oldsel", 12'hB04, 32'd0);
        cycle_en_i = 1'b1;
        event_i    = 16'h0004;
        tick();
        event_i    = '0;
        cycle_en_i = 1'b0;
        expect_read("hpm4_1", 12'hB04, 32'd1);
        csr_write(12'h325, 32'd17);
        csr_write(12'h326, 32'd16);
        cycle_en_i = 1'b1;
        event_i    = '1;
        tick();
        event_i    = '0;
        cycle_en_i = 1'b0;
        expect_read("hpm5_sel17", 12'hB05, 32'd0);
        expect_read("hpm6_sel16", 12'hB06, 32'd1);

        csr_write(MCYCLE, 32'd100);
        csr_write(MCOUNTINHIBIT, 32'h1);
        cycle_en_i = 1'b1;
        repeat (8) tick();
        cycle_en_i = 1'b0;
        expect_read("inhibit_frozen", MCYCLE, 32'd100);
        cycle_en_i = 1'b1;
        csr_write(MCOUNTINHIBIT, 32'h0);
        repeat (3) tick();
        cycle_en_i = 1'b0;
        expect_read("inhibit_resume", MCYCLE, 32'd103);
        csr_write(MCOUNTINHIBIT, 32'hFFFF_FFFF);
        expect_read("inhibit_mask", MCOUNTINHIBIT, 32'h0000_007D);
        csr_write(MCOUNTINHIBIT, 32'h0);

        csr_write(MCYCLE, 32'hFFFF_FFFF);
        csr_write(MCYCLEH, 32'h0);
        cycle_en_i = 1'b1;
        tick();
        cycle_en_i = 1'b0;
        expect_read("carry_hi", MCYCLEH, 32'd1);
        expect_read("carry_lo", MCYCLE, 32'd0);

        cycle_en_i  = 1'b1;
        rd_en_i     = 1'b1;
        wr_en_i     = 1'b1;
        csr_idx_i   = MCYCLE;
        csr_wdata_i = 32'h1234;
        #1;
        check("read_prewrite", csr_rdata_o, 32'd0);
        tick();
        wr_en_i = 1'b0;
        csr_write(MCYCLEH, 32'd7);
        cycle_en_i = 1'b0;
        expect_read("wr_lo_noinc", MCYCLE, 32'h1234);
        expect_read("wr_hi_value", MCYCLEH, 32'd7);
        rd_en_i = 1'b0;
        #1;
        check("rd_en_low", csr_rdata_o, 32'd0);
        check("rd_en_low_hit", 32'(csr_hit_o), 32'd1);

        csr_write(MHPMCOUNTER3H_BASE, 32'hFFFF_FFFF);
        expect_read("hi_width", MHPMCOUNTER3H_BASE, 32'h0000_00FF);
        csr_write(MHPMCOUNTER3_BASE, 32'hFFFF_FFFF);
        cycle_en_i = 1'b1;
        event_i    = 16'h0002;
        tick();
        event_i    = '0;
        cycle_en_i = 1'b0;
        expect_read("wrap_lo", MHPMCOUNTER3_BASE, 32'd0);
        expect_read("wrap_hi", MHPMCOUNTER3H_BASE, 32'd0);
`ifdef CERES_HPM_OVF_EN
        expect_read("of_set", MHPMEVENT3_BASE, 32'h8000_0002);
        tick();
        check("irq_set", 32'(ovf_irq_o), 32'd1);
        csr_write(MHPMEVENT3_BASE, 32'h2);
        expect_read("of_clear", MHPMEVENT3_BASE, 32'h2);
        tick();
        check("irq_clear", 32'(ovf_irq_o), 32'd0);
`else
        expect_read("of_absent", MHPMEVENT3_BASE, 32'h2);
        tick();
        check("irq_tied", 32'(ovf_irq_o), 32'd0);
`endif
        csr_write(MHPMCOUNTER3H_BASE, 32'hFF);
        csr_write(MHPMCOUNTER3_BASE, 32'hFFFF_FFFF);
        cycle_en_i = 1'b1;
        event_i    = 16'h0002;
        csr_write(MHPMEVENT3_BASE, 32'h8000_0002);
        event_i    = '0;
        cycle_en_i = 1'b0;
        expect_read("of_write_wins", MHPMEVENT3_BASE, 32'h2);
        expect_read("wrap2_lo", MHPMCOUNTER3_BASE, 32'd0);

        expect_read("unimpl_rd", 12'hB1F, 32'd0);
        check("unimpl_hit", 32'(csr_hit_o), 32'd1);
        csr_write(12'hB1F, 32'd5);
        expect_read("unimpl_wr", 12'hB1F, 32'd0);
        expect_read("b01_rd", 12'hB01, 32'd0);
        check("b01_nohit", 32'(csr_hit_o), 32'd0);
        expect_read("ev321_rd", 12'h321, 32'd0);
        check("ev321_nohit", 32'(csr_hit_o), 32'd0);
        expect_read("ev33f_rd", 12'h33F, 32'd0);
        check("ev33f_hit", 32'(csr_hit_o), 32'd1);
        csr_write(MCYCLE, 32'h42);
        csr_write(CYCLE, 32'h55);
        expect_read("shadow_wr_ign", MCYCLE, 32'h42);
        expect_read("shadow_rd", CYCLE, 32'h42);

        cycle_en_i = 1'b1;
        retire_i   = 1'b1;
        repeat (5) tick();
        #2;
        rst_ni = 1'b0;
        expect_read("arst_mcycle", MCYCLE, 32'd0);
        expect_read("arst_mcycleh", MCYCLEH, 32'd0);
        expect_read("arst_minstret", MINSTRET, 32'd0);
        expect_read("arst_event4", 12'h324, 32'd0);
        cycle_en_i = 1'b0;
        retire_i   = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        expect_read("post_rst_mcycle", MCYCLE, 32'd0);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
